multi_game_engine: RTL and testbench

- Parametrised, self-contained successor to the single-channel counter / win-lose / score / game-state chain.
- Runs NUM_CH independent games in parallel.
- Each channel has:
  - an up/down step counter with load,
  - registered win/lose detection,
  - win and lose score counters,
  - a game-state FSM with a configurable target score.
- Game-over exit is either by a restart handshake or by timed auto-clear, replacing the external clear-reset controller.

---
 rtl/multi_game_engine_if.sv | 30 +++
 rtl/multi_game_engine.sv | 134 +++++++++++++
 tb/tb_multi_game_engine.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/multi_game_engine_if.sv
// Bus bundle for multi_game_engine: per-channel step/load/restart inputs and
// per-channel counter, pulse, score and game-state outputs, packed by channel.
interface multi_game_engine_if #(
  parameter int NUM_CH  = 2,
  parameter int SIZE    = 4,
  parameter int SCORE_W = 4
);
  logic [2*NUM_CH-1:0]       control_i;
  logic [NUM_CH-1:0]         init_c_i;
  logic [SIZE*NUM_CH-1:0]    init_l_i;
  logic [NUM_CH-1:0]         restart_i;
  logic [SIZE*NUM_CH-1:0]    count_o;
  logic [NUM_CH-1:0]         winner_o;
  logic [NUM_CH-1:0]         loser_o;
  logic [SCORE_W*NUM_CH-1:0] w_count_o;
  logic [SCORE_W*NUM_CH-1:0] l_count_o;
  logic [NUM_CH-1:0]         gameover_o;
  logic [2*NUM_CH-1:0]       who_o;
  logic                      any_over_o;

  modport slave (
    input  control_i, init_c_i, init_l_i, restart_i,
    output count_o, winner_o, loser_o, w_count_o, l_count_o, gameover_o, who_o, any_over_o
  );

  modport master (
    output control_i, init_c_i, init_l_i, restart_i,
    input  count_o, winner_o, loser_o, w_count_o, l_count_o, gameover_o, who_o, any_over_o
  );
endinterface

// File: rtl/multi_game_engine.sv
// NUM_CH independent games: up/down step counter with load, registered
// win/lose pulses, score counters and a PLAY/OVER FSM with restart or auto-clear.
module multi_game_engine #(
  parameter int NUM_CH      = 2,
  parameter int SIZE        = 4,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 4,
  parameter int AUTO_CLEAR  = 0,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  multi_game_engine_if.slave  bus
);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

  logic [NUM_CH-1:0] gameover_all;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t              state_q, state_d;
      logic [SIZE-1:0]     count_q, count_d, stepped, step_val;
      logic                win_q, win_d, lose_q, lose_d;
      logic [SCORE_W-1:0]  wsc_q, wsc_d, lsc_q, lsc_d;
      logic [1:0]          who_q, who_d;
      logic [HOLD_W-1:0]   hold_q, hold_d;
      logic [1:0]          ctrl;
      logic                load, rst_req;
      logic [SIZE-1:0]     load_val;
      logic                win_done, lose_done, exit_over;

      assign ctrl     = bus.control_i[gi*2 +: 2];
      assign load     = bus.init_c_i[gi];
      assign load_val = bus.init_l_i[gi*SIZE +: SIZE];
      assign rst_req  = bus.restart_i[gi];

      always_comb begin
        case (ctrl)
          2'b00:   step_val = SIZE'(1);
          2'b01:   step_val = SIZE'(2);
          2'b10:   step_val = '1;
          default: step_val = ~SIZE'(1);
        endcase
        stepped = count_q + step_val;
      end

      // The score increment that lands on WIN_SCORE is the edge that ends the game.
      assign win_done  = win_q  && ((wsc_q + SCORE_W'(1)) == SCORE_W'(WIN_SCORE));
      assign lose_done = lose_q && ((lsc_q + SCORE_W'(1)) == SCORE_W'(WIN_SCORE));
      assign exit_over = (AUTO_CLEAR != 0) ? (hold_q == HOLD_W'(HOLD_CYCLES - 1)) : rst_req;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q <= PLAY;
          count_q <= '0;
          win_q   <= 1'b0;
          lose_q  <= 1'b0;
          wsc_q   <= '0;
          lsc_q   <= '0;
          who_q   <= 2'b00;
          hold_q  <= '0;
        end else begin
          state_q <= state_d;
          count_q <= count_d;
          win_q   <= win_d;
          lose_q  <= lose_d;
          wsc_q   <= wsc_d;
          lsc_q   <= lsc_d;
          who_q   <= who_d;
          hold_q  <= hold_d;
        end
      end

      always_comb begin
        state_d = state_q;
        case (state_q)
          PLAY:    if (win_done || lose_done) state_d = OVER;
          default: if (exit_over)             state_d = PLAY;
        endcase
      end

      always_comb begin
        count_d = count_q;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        wsc_d   = wsc_q;
        lsc_d   = lsc_q;
        who_d   = who_q;
        hold_d  = hold_q;
        case (state_q)
          PLAY: begin
            if (win_q)  wsc_d = wsc_q + SCORE_W'(1);
            if (lose_q) lsc_d = lsc_q + SCORE_W'(1);
            if (win_done) begin
              who_d = 2'b10;
            end else if (lose_done) begin
              who_d = 2'b01;
            end else if (load) begin
              count_d = load_val;
            end else begin
              count_d = stepped;
              win_d   = (stepped == '1);
              lose_d  = (stepped == '0);
            end
          end
          default: begin
            if (exit_over) begin
              count_d = '0;
              wsc_d   = '0;
              lsc_d   = '0;
              who_d   = 2'b00;
              hold_d  = '0;
            end else if (AUTO_CLEAR != 0) begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        endcase
      end

      assign bus.count_o[gi*SIZE +: SIZE]         = count_q;
      assign bus.winner_o[gi]                     = win_q;
      assign bus.loser_o[gi]                      = lose_q;
      assign bus.w_count_o[gi*SCORE_W +: SCORE_W] = wsc_q;
      assign bus.l_count_o[gi*SCORE_W +: SCORE_W] = lsc_q;
      assign bus.who_o[gi*2 +: 2]                 = who_q;
      assign gameover_all[gi]                     = (state_q == OVER);
    end
  endgenerate

  assign bus.gameover_o = gameover_all;
  assign bus.any_over_o = |gameover_all;
endmodule

// File: tb/tb_multi_game_engine.sv
// Directed bench: a vector table on a restart-mode engine plus hand-written
// reset and auto-clear sequences on a second engine with AUTO_CLEAR=1.
module tb_multi_game_engine;
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  multi_game_engine_if #(.NUM_CH(2), .SIZE(4), .SCORE_W(4)) ifa ();
  multi_game_engine_if #(.NUM_CH(2), .SIZE(4), .SCORE_W(4)) ifb ();

  multi_game_engine #(.NUM_CH(2), .SIZE(4), .SCORE_W(4), .WIN_SCORE(2),
                      .AUTO_CLEAR(0), .HOLD_CYCLES(4))
    dut_a (.clk(clk), .reset(rst_a), .bus(ifa));

  multi_game_engine #(.NUM_CH(2), .SIZE(4), .SCORE_W(4), .WIN_SCORE(2),
                      .AUTO_CLEAR(1), .HOLD_CYCLES(3))
    dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  typedef struct {
    logic [1:0] c0, c1, ld;
    logic [3:0] l0, l1;
    logic [1:0] rs;
    logic [3:0] q0, q1;
    logic [1:0] win, lose;
    logic [3:0] wc0, lc0, wc1, lc1;
    logic [1:0] go, who0, who1;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] ld,
                         input logic [3:0] l0, input logic [3:0] l1, input logic [1:0] rs);
    ifa.control_i = {c1, c0};
    ifa.init_c_i  = ld;
    ifa.init_l_i  = {l1, l0};
    ifa.restart_i = rs;
  endtask

  task automatic drive_b(input logic [1:0] c1, input logic ld1, input logic [3:0] l1,
                         input logic rs1);
    ifb.control_i = {c1, 2'b00};
    ifb.init_c_i  = {ld1, 1'b1};
    ifb.init_l_i  = {l1, 4'h5};
    ifb.restart_i = {rs1, 1'b0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    // c0, c1, ld, l0, l1, rs | q0, q1, win, lose, wc0, lc0, wc1, lc1, go, who0, who1
    vecs[0]  = '{2'b00, 2'b00, 2'b11, 4'hD, 4'h5, 2'b00, 4'hD, 4'h5, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'hE, 4'h6, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[2]  = '{2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'hF, 4'h7, 2'b01, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[3]  = '{2'b01, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'h1, 4'h8, 2'b00, 2'b00, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[4]  = '{2'b10, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'h0, 4'h9, 2'b00, 2'b01, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[5]  = '{2'b11, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'hE, 4'hA, 2'b00, 2'b00, 4'd1, 4'd1, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[6]  = '{2'b00, 2'b00, 2'b01, 4'hF, 4'h0, 2'b00, 4'hF, 4'hB, 2'b00, 2'b00, 4'd1, 4'd1, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[7]  = '{2'b00, 2'b00, 2'b01, 4'h0, 4'h0, 2'b00, 4'h0, 4'hC, 2'b00, 2'b00, 4'd1, 4'd1, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[8]  = '{2'b00, 2'b00, 2'b01, 4'hE, 4'h0, 2'b00, 4'hE, 4'hD, 2'b00, 2'b00, 4'd1, 4'd1, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[9]  = '{2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'hF, 4'hE, 2'b01, 2'b00, 4'd1, 4'd1, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[10] = '{2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'hF, 4'hF, 2'b10, 2'b00, 4'd2, 4'd1, 4'd0, 4'd0, 2'b01, 2'b10, 2'b00};
    vecs[11] = '{2'b11, 2'b00, 2'b01, 4'h3, 4'h0, 2'b00, 4'hF, 4'h0, 2'b00, 2'b10, 4'd2, 4'd1, 4'd1, 4'd0, 2'b01, 2'b10, 2'b00};
    vecs[12] = '{2'b00, 2'b10, 2'b00, 4'h0, 4'h0, 2'b01, 4'h0, 4'hF, 2'b10, 2'b00, 4'd0, 4'd0, 4'd1, 4'd1, 2'b00, 2'b00, 2'b00};
    vecs[13] = '{2'b00, 2'b10, 2'b00, 4'h0, 4'h0, 2'b00, 4'h1, 4'hF, 2'b00, 2'b00, 4'd0, 4'd0, 4'd2, 4'd1, 2'b10, 2'b00, 2'b10};
    vecs[14] = '{2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 2'b01, 4'h2, 4'hF, 2'b00, 2'b00, 4'd0, 4'd0, 4'd2, 4'd1, 2'b10, 2'b00, 2'b10};
    vecs[15] = '{2'b10, 2'b00, 2'b00, 4'h0, 4'h0, 2'b10, 4'h1, 4'h0, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};

    drive_a(2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00);
    drive_b(2'b00, 1'b0, 4'h0, 1'b0);

    // Reset asserted mid-run with random activity on the inputs
    tick;
    rst_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      drive_a(r[1:0], r[3:2], r[5:4], r[11:8], r[15:12], r[17:16]);
      tick;
    end
    #2;
    rst_a = 1'b0;
    #1;
    $display("reset asserted: count=%h win=%b lose=%b go=%b", ifa.count_o, ifa.winner_o, ifa.loser_o, ifa.gameover_o);
    check("rst_count",   ifa.count_o,    0);
    check("rst_winner",  ifa.winner_o,   0);
    check("rst_loser",   ifa.loser_o,    0);
    check("rst_wcount",  ifa.w_count_o,  0);
    check("rst_lcount",  ifa.l_count_o,  0);
    check("rst_gameover",ifa.gameover_o, 0);
    check("rst_who",     ifa.who_o,      0);
    check("rst_any",     32'(ifa.any_over_o), 0);
    tick;
    check("rst_hold_count", ifa.count_o, 0);
    drive_a(2'b00, 2'b00, 2'b11, 4'h0, 4'h0, 2'b00);
    rst_a = 1'b1;
    tick;
    $display("reset released: count=%h lose=%b who=%b", ifa.count_o, ifa.loser_o, ifa.who_o);
    check("rel_count", ifa.count_o, 0);
    check("rel_loser", ifa.loser_o, 0);
    check("rel_who",   ifa.who_o,   0);

    for (int i = 0; i < 16; i++) begin
      drive_a(vecs[i].c0, vecs[i].c1, vecs[i].ld, vecs[i].l0, vecs[i].l1, vecs[i].rs);
      tick;
      $display("vec %0d: count=%h win=%b lose=%b wc=%h lc=%h go=%b who=%b any=%b", i,
               ifa.count_o, ifa.winner_o, ifa.loser_o, ifa.w_count_o, ifa.l_count_o,
               ifa.gameover_o, ifa.who_o, ifa.any_over_o);
      check($sformatf("v%0d_count", i),  ifa.count_o,    {vecs[i].q1, vecs[i].q0});
      check($sformatf("v%0d_winner", i), ifa.winner_o,   vecs[i].win);
      check($sformatf("v%0d_loser", i),  ifa.loser_o,    vecs[i].lose);
      check($sformatf("v%0d_wcount", i), ifa.w_count_o,  {vecs[i].wc1, vecs[i].wc0});
      check($sformatf("v%0d_lcount", i), ifa.l_count_o,  {vecs[i].lc1, vecs[i].lc0});
      check($sformatf("v%0d_gameover", i), ifa.gameover_o, vecs[i].go);
      check($sformatf("v%0d_who", i),    ifa.who_o,      {vecs[i].who1, vecs[i].who0});
      check($sformatf("v%0d_any", i),    32'(ifa.any_over_o), 32'(|vecs[i].go));
    end

    // Auto-clear engine: two ch1 losses end the game, OVER lasts 3 cycles
    drive_b(2'b00, 1'b1, 4'h1, 1'b0);
    rst_b = 1'b1;
    tick;
    check("b_load", ifb.count_o[7:4], 4'h1);
    drive_b(2'b10, 1'b0, 4'h0, 1'b0);
    tick;
    check("b_lose1", 32'(ifb.loser_o[1]), 1);
    drive_b(2'b00, 1'b1, 4'h1, 1'b0);
    tick;
    check("b_lc1", ifb.l_count_o[7:4], 4'd1);
    drive_b(2'b10, 1'b0, 4'h0, 1'b0);
    tick;
    check("b_lose2", 32'(ifb.loser_o[1]), 1);
    drive_b(2'b00, 1'b0, 4'h0, 1'b0);
    tick;
    $display("b over: count=%h lc=%h go=%b who=%b", ifb.count_o, ifb.l_count_o, ifb.gameover_o, ifb.who_o);
    check("b_over_go",  ifb.gameover_o, 2'b10);
    check("b_over_who", ifb.who_o,      4'b0100);
    check("b_over_lc",  ifb.l_count_o[7:4], 4'd2);
    check("b_over_cnt", ifb.count_o[7:4], 4'h0);
    check("b_over_any", 32'(ifb.any_over_o), 1);
    for (int k = 0; k < 3; k++) begin
      drive_b(2'b00, 1'b0, 4'h0, k == 0);
      tick;
      $display("b hold %0d: go=%b who=%b lc=%h", k, ifb.gameover_o, ifb.who_o, ifb.l_count_o);
      check($sformatf("b_hold%0d_go", k), 32'(ifb.gameover_o[1]), (k < 2) ? 1 : 0);
    end
    check("b_clr_lc",  ifb.l_count_o, 0);
    check("b_clr_who", ifb.who_o,     0);
    check("b_clr_cnt", ifb.count_o[7:4], 4'h0);
    drive_b(2'b00, 1'b0, 4'h0, 1'b0);
    tick;
    check("b_resume", ifb.count_o[7:4], 4'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
